// File: rtl/ahb_bram_bridge.sv
// ahb_bram_bridge
//   AHB-Lite slave in front of a 32-bit byte-enabled dual-port block RAM.
//   Every transfer completes with zero wait states. A read that immediately
//   follows a write to the same word gets the written bytes forwarded, because
//   the RAM returns the old contents in that case.
//
// Ports
//   clka, rsta         clock (shared with RAM) and synchronous active-high reset
//   HSEL..HREADY       AHB-Lite slave address/data phase inputs
//   HREADYOUT, HRESP   constant 1 / OKAY
//   HRDATA             read data, valid in the read data phase
//   addra, dina, wea   RAM write port, driven during a write data phase
//   addrb, doutb       RAM read port; doutb is registered inside the RAM
module ahb_bram_bridge #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [ADDR_WIDTH-1:0] addrb,
  output logic [31:0]           dina,
  output logic [3:0]            wea,
  input  logic [31:0]           doutb
);

  logic                  acc;
  logic [ADDR_WIDTH-1:0] haddr_w;
  logic [3:0]            be_d;
  logic                  fwd_d;

  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [3:0]            be_q;
  logic                  fwd_hit;
  logic [3:0]            fwd_be;
  logic [31:0]           fwd_data;

  // Bits above the RAM size and the non-NONSEQ/SEQ bit of HTRANS are unused.
  logic unused_bits;
  assign unused_bits = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  assign acc     = HSEL & HTRANS[1] & HREADY;
  assign haddr_w = HADDR[ADDR_WIDTH+1:2];

  // Byte-lane strobes for the address phase.
  always_comb begin
    be_d = 4'b1111;
    if (HSIZE == 3'd0)
      be_d = 4'b0001 << HADDR[1:0];
    else if (HSIZE == 3'd1)
      be_d = HADDR[1] ? 4'b1100 : 4'b0011;
  end

  // Read address phase overlapping a write data phase to the same word.
  assign fwd_d = acc & ~HWRITE & wr_q & (haddr_w == waddr_q);

  always_ff @(posedge clka) begin
    if (rsta) begin
      wr_q    <= 1'b0;
      be_q    <= '0;
      fwd_hit <= 1'b0;
    end else if (HREADY) begin
      wr_q    <= acc & HWRITE;
      be_q    <= be_d;
      fwd_hit <= fwd_d;
    end
  end

  always_ff @(posedge clka) begin
    if (HREADY)
      waddr_q <= haddr_w;
    if (fwd_d) begin
      fwd_be   <= be_q;
      fwd_data <= HWDATA;
    end
  end

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  // Write port: reset suppresses any write in its data phase.
  assign wea   = (wr_q && !rsta) ? be_q : '0;
  assign addra = waddr_q;
  assign dina  = HWDATA;

  assign addrb = haddr_w;

  always_comb begin
    HRDATA = doutb;
    if (fwd_hit) begin
      for (int unsigned i = 0; i < 4; i++)
        if (fwd_be[i])
          HRDATA[8*i +: 8] = fwd_data[8*i +: 8];
    end
  end

endmodule

// File: doc/ahb_bram_bridge.md
Name: ahb_bram_bridge

Overview:
- AHB-Lite slave that converts Cortex-M0 bus transfers into the dual-port block-RAM port set: write port addra/dina/wea and read port addrb/doutb, with one-cycle registered read data.
- Sits directly upstream of the 32-bit byte-enabled block RAM, between the AHB interconnect and the RAM.
- Zero-wait-state for all transfers.
- Resolves the write-then-read hazard to the same word by byte-lane forwarding.

Parameters:
- ADDR_WIDTH, 14, RAM word-address width. RAM size is 2**ADDR_WIDTH words; the bridge decodes HADDR[ADDR_WIDTH+1:2].

Ports:
- clka  in  1  clock; RAM runs on the same clock.
- rsta  in  1  reset; synchronous, active-high.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address.
- HTRANS  in  2  transfer type; only NONSEQ/SEQ (HTRANS[1]=1) are valid.
- HSIZE  in  3  transfer size.
- HWRITE  in  1  1 = write.
- HWDATA  in  32  write data, data phase.
- HREADY  in  1  bus ready; an address phase is accepted only when this is high.
- HREADYOUT  out  1  always 1 (zero wait).
- HRESP  out  1  always 0 (OKAY).
- HRDATA  out  32  read data, data phase.
- addra  out  ADDR_WIDTH  RAM write word address.
- addrb  out  ADDR_WIDTH  RAM read word address.
- dina  out  32  RAM write data.
- wea  out  4  RAM byte write enables.
- doutb  in  32  RAM read data, registered inside the RAM, 1-cycle latency.

Behaviour:
- Accept condition: acc = HSEL & HTRANS[1] & HREADY. IDLE and BUSY transfers, and transfers with HSEL low, cause no RAM write and no state change except for clearing the phase flags.

Byte strobes, computed in the address phase:
- HSIZE=0: one-hot on HADDR[1:0].
- HSIZE=1: HADDR[1] ? 4'b1100 : 4'b0011; HADDR[0] is ignored.
- HSIZE>=2: 4'b1111.

Address phase registers, loaded on every cycle where HREADY=1:
- wr_q = acc & HWRITE.
- waddr_q = HADDR[ADDR_WIDTH+1:2].
- be_q = strobes.
- Upper address bits are ignored, so accesses wrap/alias modulo RAM size.
- When HREADY=0, the registers hold.

Write data phase (wr_q=1):
- wea = be_q, addra = waddr_q, dina = HWDATA, all combinational.
- The RAM commits at the end of the data-phase cycle.
- When wr_q=0: wea = 0, and addra/dina are don't-care.

Read path:
- addrb = HADDR[ADDR_WIDTH+1:2], combinational, every cycle.
- RAM samples addrb at the end of the address phase.
- doutb is valid throughout the following data phase.

Hazard forwarding:
- Condition: a read address phase (acc & !HWRITE) coincides with a write data phase (wr_q=1) and both have the same word address.
- In that case the RAM returns the old word, so the bridge registers fwd_hit=1, fwd_be=be_q and fwd_data=HWDATA at that edge.
- In the next cycle, byte i of HRDATA = fwd_be[i] ? fwd_data byte i : doutb byte i.
- fwd_hit clears on any other accepted cycle.
- One-deep forwarding is sufficient: any earlier write has already committed before the read sample edge.
- When fwd_hit=0: HRDATA = doutb.
- HRDATA content outside a read data phase is don't-care.

Reset:
- rsta=1 clears wr_q, be_q and fwd_hit.
- wea is forced to 0 during any cycle with rsta=1, so a write in its data phase is dropped.
- HREADYOUT=1 and HRESP=0 both during and after reset.
- The first transfer after rsta deasserts is handled normally.

Stalls:
- If HREADY=0 because another slave is extending its data phase, no new phase is captured.
- A pending own data phase cannot stall, since HREADYOUT=1.

Test Plan:
- Reset: hold rsta 2 cycles with HSEL=1, HTRANS=NONSEQ, HWRITE=1 -> wea=0 throughout, HREADYOUT=1, HRESP=0; a subsequent read of that address returns the RAM preload value.
- Word write then read, non-adjacent: write 0xDEADBEEF to 0x0000_0010, one IDLE cycle, then read 0x10 -> HRDATA=0xDEADBEEF one cycle after the read address phase; wea=4'b1111 and addra=4 during the write data phase.
- Byte/halfword strobes: byte write 0xAA at 0x21, then halfword write 0x5566 at 0x22 -> wea=4'b0010, then 4'b1100; a word read of 0x20 returns 0x5566AAxx, where xx is the prior byte 0.
- Back-to-back forwarding, partial: word 0x11223344 resident at 0x40; byte write 0x99 to 0x43 immediately followed by a read of 0x40 -> HRDATA=0x99223344 with zero wait states.
- Back-to-back write/write/read of the same word with different byte lanes -> read returns both updates merged; no forwarding false hit on a read to a different address (e.g. 0x44 returns its own contents).
- Stall and idle: HREADY=0 for 3 cycles while HADDR/HTRANS are presented -> no wea pulse; IDLE/BUSY transfers with HSEL=1 -> wea=0. Additionally, an address above the RAM size (0x0001_0010 with ADDR_WIDTH=14) aliases to word 4.
